// File: rtl/mhp_frame_engine.sv
// mhp_frame_engine: receives one payload frame from the RX byte FIFO,
// then echoes it (or a pad-only reply) padded to MIN_LEN into the TX FIFO.
module mhp_frame_engine #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int MIN_LEN = 46,
   parameter int GAP_CYCLES = 4,
   parameter logic [DATA_W-1:0] PAD_BYTE = '0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_auto,
   input  logic              i_mode,
   input  logic              i_send,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic              i_rready,
   output logic              o_rreq,
   output logic [DATA_W-1:0] o_wdata,
   input  logic              i_wready,
   output logic              o_wvalid,
   output logic              o_done,
   output logic              o_busy,
   output logic              o_overflow,
   output logic [ADDR_W:0]   o_len,
   output logic [15:0]       o_csum,
   output logic [15:0]       o_frames
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int GW = $clog2(GAP_CYCLES+1);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] MIN_L = (ADDR_W+1)'(MIN_LEN);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES-1);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RX   = 3'd1;
   localparam logic [2:0] HOLD = 3'd2;
   localparam logic [2:0] TX   = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic              rreq_q;
   logic              ovf_q, ovf_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [15:0]       csum_q, csum_d;
   logic [15:0]       frames_q, frames_d;
   logic              mode_q, mode_d;
   logic              wvalid_q, wvalid_d;
   logic [ADDR_W:0]   cur_q, cur_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] raddr;
   logic [ADDR_W:0]   tx_n;
   logic [DATA_W-1:0] tx_byte;
   logic              rreq, wr_en, fire, pad;
   logic              go_rx, go_tx;

   assign rreq    = (state_q == RX) && i_rready && !rreq_q;
   assign wr_en   = rreq && (wptr_q < DEPTH_L);
   assign fire    = wvalid_q && i_wready;
   assign tx_n    = (len_q > MIN_L) ? len_q : MIN_L;
   assign pad     = mode_q || (cur_q >= len_q);
   assign tx_byte = pad ? PAD_BYTE : rdata_q;
   // Read address follows the next-state index so the registered
   // read always holds the byte presented in the following cycle.
   assign raddr   = cur_d[ADDR_W-1:0];

   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wptr_q[ADDR_W-1:0]] <= i_rdata;
      rdata_q <= mem[raddr];
   end

   always_comb begin
      state_d  = state_q;
      wptr_d   = wptr_q;
      gap_d    = gap_q;
      ovf_d    = ovf_q;
      len_d    = len_q;
      csum_d   = csum_q;
      frames_d = frames_q;
      mode_d   = mode_q;
      wvalid_d = wvalid_q;
      cur_d    = cur_q;
      go_rx    = 1'b0;
      go_tx    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_rready) go_rx = 1'b1;
            else if (i_send) go_tx = 1'b1;
         end
         RX: begin
            if (rreq) begin
               gap_d = '0;
               if (wptr_q < DEPTH_L) wptr_d = wptr_q + 1'b1;
               else ovf_d = 1'b1;
            end else if (!i_rready) begin
               if (gap_q == GAP_LAST) begin
                  len_d    = wptr_q;
                  frames_d = frames_q + 16'd1;
                  if (i_auto) go_tx = 1'b1;
                  else state_d = HOLD;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (i_send) go_tx = 1'b1;
            else if (i_rready) go_rx = 1'b1;
         end
         TX: begin
            if (fire) begin
               csum_d = csum_q + 16'(tx_byte);
               cur_d  = cur_q + 1'b1;
               if (cur_q + 1'b1 == tx_n) begin
                  wvalid_d = 1'b0;
                  state_d  = DONE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (go_rx) begin
         state_d = RX;
         wptr_d  = '0;
         gap_d   = '0;
         ovf_d   = 1'b0;
      end
      if (go_tx) begin
         state_d  = TX;
         mode_d   = i_mode;
         csum_d   = '0;
         cur_d    = '0;
         wvalid_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         wptr_q   <= '0;
         gap_q    <= '0;
         rreq_q   <= 1'b0;
         ovf_q    <= 1'b0;
         len_q    <= '0;
         csum_q   <= '0;
         frames_q <= '0;
         mode_q   <= 1'b0;
         wvalid_q <= 1'b0;
         cur_q    <= '0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         gap_q    <= gap_d;
         rreq_q   <= rreq;
         ovf_q    <= ovf_d;
         len_q    <= len_d;
         csum_q   <= csum_d;
         frames_q <= frames_d;
         mode_q   <= mode_d;
         wvalid_q <= wvalid_d;
         cur_q    <= cur_d;
      end
   end

   assign o_rreq     = rreq;
   assign o_wdata    = wvalid_q ? tx_byte : '0;
   assign o_wvalid   = wvalid_q;
   assign o_done     = (state_q == DONE);
   assign o_busy     = (state_q == RX) || (state_q == TX);
   assign o_overflow = ovf_q;
   assign o_len      = len_q;
   assign o_csum     = csum_q;
   assign o_frames   = frames_q;

endmodule
